// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - handshake, data and status bundle for fifo_sync_param
interface fifo_sync_param_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              flush;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   cnt;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en, flush,
    input  rd_data, empty, full, almost_full, almost_empty, cnt, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, flush,
    output rd_data, empty, full, almost_full, almost_empty, cnt, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with count, watermarks, sticky errors, flush
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered (1-cycle latency).
module fifo_sync_param #(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input logic               clk,
  input logic               rst,
  fifo_sync_param_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C     = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C     = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              empty, full, rd_ok, wr_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_FULL);

  // flush masks both ports so nothing is stored or popped in that cycle
  assign rd_ok = bus.rd_en & ~empty & ~bus.flush;
  assign wr_ok = bus.wr_en & (~full | rd_ok) & ~bus.flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_ok & ~rd_ok)      cnt_d = cnt_q + 1'b1;
      else if (rd_ok & ~wr_ok) cnt_d = cnt_q - 1'b1;
      if (bus.wr_en & ~wr_ok) overflow_d  = 1'b1;
      if (bus.rd_en & empty)  underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= bus.wr_data;
  end

`ifdef FIFO_FWFT_EN
  assign bus.rd_data = empty ? '0 : mem[rd_ptr_q];
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_ok) rd_data_d = mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

  assign bus.rd_data = rd_data_q;
`endif

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (cnt_q >= AF_C);
  assign bus.almost_empty = (cnt_q <= AE_C);
  assign bus.cnt          = cnt_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
